// File: rtl/fetch_sequencer.sv
// Program-counter and fetch sequencer for the 9-bit accumulator ISA.
// Steps one instruction per cycle. Taken branches jump to absolute targets
// held in a writable lookup table. Reports run status and a saturating
// count of cycles spent running.
module fetch_sequencer #(
    parameter int PC_W      = 10,
    parameter int CNT_W     = 16,
    parameter int LUT_DEPTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Branch,
    input  logic             Taken,
    input  logic             Halt,
    input  logic [4:0]       Offset,
    input  logic             LutWe,
    input  logic [4:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [PC_W-1:0] lut [LUT_DEPTH];

    assign Running = (state == ST_RUN);
    assign Done    = (state == ST_DONE);

    // Saturating increment: sticks at all-ones instead of wrapping.
    assign cnt_inc = (CycleCount == {CNT_W{1'b1}}) ? CycleCount : CycleCount + 1'b1;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge values, independent of statement order.
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state, next-PC and next-count selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        pc_next    = PC;
        cnt_next   = CycleCount;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_next = ST_RUN;
                    pc_next    = StartAddr;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_inc;
                if (Halt)                 state_next = ST_DONE;
                else if (Branch && Taken) pc_next    = lut[Offset];
                else                      pc_next    = PC + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // PC and cycle-counter registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            PC         <= '0;
            CycleCount <= '0;
        end else begin
            PC         <= pc_next;
            CycleCount <= cnt_next;
        end
    end

    // Branch-target table; the lookup above reads the pre-edge contents,
    // so a same-cycle write to the looked-up entry is seen one edge later.
    always_ff @(posedge Clk) begin
        // NOTE: the table is built from flops with a reset so that every
        // entry reads 0 after reset; a RAM macro could not be cleared in
        // one cycle.
        if (!Reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else if (LutWe) begin
            lut[LutAddr] <= LutData;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run, all checked against a behavioural model.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n, Start, Branch, Taken, Halt, LutWe;
    logic [9:0]  StartAddr, LutData;
    logic [4:0]  Offset, LutAddr;
    logic [9:0]  pc_a, pc_b;
    logic        run_a, run_b, done_a, done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    fetch_sequencer u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .Taken(Taken), .Halt(Halt), .Offset(Offset),
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .PC(pc_a), .Running(run_a), .Done(done_a), .CycleCount(cnt_a)
    );

    fetch_sequencer #(.CNT_W(4)) u_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .Taken(Taken), .Halt(Halt), .Offset(Offset),
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .PC(pc_b), .Running(run_b), .Done(done_b), .CycleCount(cnt_b)
    );

    // Behavioural model: mode, program counter, unbounded cycle tally, table.
    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_pc = 0;
    int    m_cycles = 0;
    int    m_lut [32];

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step();
        int tgt;
        if (!Reset_n) begin
            m_mode = M_IDLE; m_pc = 0; m_cycles = 0;
            for (int i = 0; i < 32; i++) m_lut[i] = 0;
        end else begin
            tgt = m_lut[Offset];
            if (m_mode == M_RUN) begin
                m_cycles++;
                if (Halt)                 m_mode = M_DONE;
                else if (Branch && Taken) m_pc = tgt;
                else                      m_pc = (m_pc + 1) % 1024;
            end else if (Start) begin
                m_mode = M_RUN; m_pc = int'(StartAddr); m_cycles = 0;
            end
            if (LutWe) m_lut[LutAddr] = int'(LutData);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 0; Branch = 0; Taken = 0; Halt = 0; LutWe = 0;
        StartAddr = '0; Offset = '0; LutAddr = '0; LutData = '0;
    endtask

    task automatic write_lut(input logic [4:0] a, input logic [9:0] d);
        LutWe = 1; LutAddr = a; LutData = d;
        tick();
        LutWe = 0;
    endtask

    task automatic take_branch(input logic [4:0] off);
        Branch = 1; Taken = 1; Offset = off;
        tick();
        Branch = 0; Taken = 0;
    endtask

    task automatic test_reset();
        Reset_n = 0; idle_inputs();
        tick(); tick();
        n_cmp++; if (pc_a !== 10'd0) begin n_bad++; $display("FAIL reset_pc: got %0d expected 0", pc_a); end
        n_cmp++; if (run_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got run=%b done=%b expected 0/0", run_a, done_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
        Reset_n = 1;
    endtask

    task automatic test_sequential();
        Start = 1; StartAddr = 10'd5;
        tick();
        Start = 0;
        n_cmp++; if (pc_a !== 10'd5 || run_a !== 1'b1) begin n_bad++; $display("FAIL start_pc: got pc=%0d run=%b expected 5/1", pc_a, run_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL start_cnt: got %0d expected 0", cnt_a); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (pc_a !== 10'(5 + k) || cnt_a !== 16'(k)) begin
                n_bad++; $display("FAIL seq_step%0d: got pc=%0d cnt=%0d expected %0d/%0d", k, pc_a, cnt_a, 5 + k, k);
            end
        end
    endtask

    task automatic test_branch();
        write_lut(5'd3, 10'd40);   // PC 8 -> 9
        tick();                    // PC 10
        n_cmp++; if (pc_a !== 10'd10) begin n_bad++; $display("FAIL pre_branch_pc: got %0d expected 10", pc_a); end
        take_branch(5'd3);
        n_cmp++; if (pc_a !== 10'd40) begin n_bad++; $display("FAIL taken_branch: got %0d expected 40", pc_a); end
        Branch = 1; Taken = 0; Offset = 5'd3;
        tick();
        Branch = 0;
        n_cmp++; if (pc_a !== 10'd41) begin n_bad++; $display("FAIL not_taken_branch: got %0d expected 41", pc_a); end
    endtask

    task automatic test_halt_restart();
        int held;
        write_lut(5'd5, 10'd20);
        take_branch(5'd5);
        n_cmp++; if (pc_a !== 10'd20) begin n_bad++; $display("FAIL reach_20: got %0d expected 20", pc_a); end
        Halt = 1; Branch = 1; Taken = 1; Offset = 5'd3;
        tick();
        idle_inputs();
        n_cmp++; if (done_a !== 1'b1 || run_a !== 1'b0 || pc_a !== 10'd20) begin
            n_bad++; $display("FAIL halt_priority: got done=%b run=%b pc=%0d expected 1/0/20", done_a, run_a, pc_a);
        end
        held = sat(m_cycles, 65535);
        n_cmp++; if (cnt_a !== 16'(held)) begin n_bad++; $display("FAIL halt_cnt: got %0d expected %0d", cnt_a, held); end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (cnt_a !== 16'(held) || done_a !== 1'b1 || pc_a !== 10'd20) begin
            n_bad++; $display("FAIL done_hold: got cnt=%0d done=%b pc=%0d expected %0d/1/20", cnt_a, done_a, pc_a, held);
        end
        Start = 1; StartAddr = 10'd0;
        tick();
        Start = 0;
        n_cmp++; if (pc_a !== 10'd0 || done_a !== 1'b0 || run_a !== 1'b1 || cnt_a !== 16'd0) begin
            n_bad++; $display("FAIL restart: got pc=%0d done=%b run=%b cnt=%0d expected 0/0/1/0", pc_a, done_a, run_a, cnt_a);
        end
    endtask

    task automatic test_wrap();
        write_lut(5'd9, 10'd1023);
        take_branch(5'd9);
        n_cmp++; if (pc_a !== 10'd1023) begin n_bad++; $display("FAIL reach_1023: got %0d expected 1023", pc_a); end
        tick();
        n_cmp++; if (pc_a !== 10'd0 || run_a !== 1'b1) begin n_bad++; $display("FAIL pc_wrap: got pc=%0d run=%b expected 0/1", pc_a, run_a); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) tick();
        n_cmp++; if (cnt_b !== 4'd15) begin n_bad++; $display("FAIL sat_small: got %0d expected 15", cnt_b); end
        n_cmp++; if (cnt_a !== 16'(sat(m_cycles, 65535))) begin n_bad++; $display("FAIL cnt_wide: got %0d expected %0d", cnt_a, sat(m_cycles, 65535)); end
    endtask

    task automatic test_lut_collision();
        write_lut(5'd7, 10'd100);
        LutWe = 1; LutAddr = 5'd7; LutData = 10'd200;
        take_branch(5'd7);
        LutWe = 0;
        n_cmp++; if (pc_a !== 10'd100) begin n_bad++; $display("FAIL collide_old: got %0d expected 100", pc_a); end
        take_branch(5'd7);
        n_cmp++; if (pc_a !== 10'd200) begin n_bad++; $display("FAIL collide_new: got %0d expected 200", pc_a); end
    endtask

    task automatic test_reset_midrun();
        write_lut(5'd2, 10'd30);
        take_branch(5'd2);
        n_cmp++; if (pc_a !== 10'd30) begin n_bad++; $display("FAIL reach_30: got %0d expected 30", pc_a); end
        Reset_n = 0; Start = 1; StartAddr = 10'd77; LutWe = 1; LutAddr = 5'd7; LutData = 10'd55;
        tick();
        idle_inputs(); Reset_n = 1;
        n_cmp++; if (pc_a !== 10'd0 || run_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 16'd0) begin
            n_bad++; $display("FAIL midrun_reset: got pc=%0d run=%b done=%b cnt=%0d expected 0/0/0/0", pc_a, run_a, done_a, cnt_a);
        end
        Branch = 1; Taken = 1; Halt = 1; Offset = 5'd2;
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        n_cmp++; if (pc_a !== 10'd0 || run_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore: got pc=%0d run=%b done=%b expected 0/0/0", pc_a, run_a, done_a);
        end
        Start = 1; StartAddr = 10'd50;
        tick();
        Start = 0;
        take_branch(5'd7);
        n_cmp++; if (pc_a !== 10'd0) begin n_bad++; $display("FAIL lut_cleared: got %0d expected 0", pc_a); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            Reset_n   = ($urandom_range(63) != 0);
            Start     = ($urandom_range(7) == 0);
            StartAddr = 10'($urandom);
            Branch    = ($urandom_range(2) == 0);
            Taken     = 1'($urandom);
            Halt      = ($urandom_range(15) == 0);
            Offset    = 5'($urandom);
            LutWe     = ($urandom_range(3) == 0);
            LutAddr   = 5'($urandom);
            LutData   = 10'($urandom);
            tick();
            n_cmp++;
            if (pc_a !== 10'(m_pc) || run_a !== (m_mode == M_RUN) || done_a !== (m_mode == M_DONE) ||
                cnt_a !== 16'(sat(m_cycles, 65535)) || cnt_b !== 4'(sat(m_cycles, 15))) begin
                n_bad++;
                $display("FAIL random_c%0d: got pc=%0d run=%b done=%b cnt=%0d cnt4=%0d expected pc=%0d mode=%s cnt=%0d cnt4=%0d",
                         c, pc_a, run_a, done_a, cnt_a, cnt_b, m_pc, m_mode.name(),
                         sat(m_cycles, 65535), sat(m_cycles, 15));
            end
        end
        idle_inputs(); Reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_halt_restart();
        test_wrap();
        test_saturation();
        test_lut_collision();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
